rr_mux: RTL and testbench
=========================

# rr_mux

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes and round-robin arbitration. Generalises the team's 2:1 combinational selector into a streaming channel selector. Sits between multiple producer datapath stages and a single consumer. The output is registered, and a compile-time option restores explicit select control.

## Interface
Parameters:
- WIDTH, 4, data width per channel (≥1)
- N, 4, number of input channels (≥2)
- SELW, $clog2(N), derived localparam, channel index width; not overridable

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i offers a word
- in_ready  output  N  channel i word is accepted this cycle (one-hot or zero)
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle
- out_chan  output  SELW  source channel index of out_data
- force  input  1  only with MUX_FORCE_EN; overrides arbitration
- force_sel  input  SELW  only with MUX_FORCE_EN; channel to force

## Operation
- Free: `free = !out_valid || out_ready`.
- Grant: if free, grant g is the first i with in_valid[i]=1, searched in the order ptr, ptr+1, …, N-1, 0, …, ptr-1. Otherwise there is no grant.
- `in_ready[g]=1` only for the granted channel. All other in_ready bits are 0. All bits are 0 when not free or when no channel is valid.
- On grant: out_data←word g, out_chan←g, out_valid←1, ptr←(g+1) mod N, with wrap from N-1 to 0.
- Free with no grant: if out_ready drained the word, out_valid←0. out_data and out_chan keep their last value.
- Not free: out_data, out_chan and ptr hold, and out_valid stays 1.
- Simultaneous drain and grant in the same cycle: the new word replaces the old one and out_valid stays 1, giving full throughput.
- Fairness: a continuously valid channel waits at most N-1 grants.
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0. All in_ready bits are 0 while rst=1.
- Reset mid-operation: the held word is discarded and not presented, and ptr returns to 0.

## Timing
- Latency: an accepted word appears on out_data/out_valid on the clock edge after the in_valid&&in_ready cycle (1 cycle).
- Throughput: 1 word per cycle when out_ready=1.
- in_ready is combinational from in_valid, out_valid, out_ready, ptr and, when configured, force/force_sel. No outputs depend combinationally on in_data.
- Producers must hold in_valid and in_data stable until in_ready is seen. The block does not require this but never accepts without in_ready.
- out_data and out_chan are stable while out_valid=1 and out_ready=0.

## Configuration
- Macro: MUX_FORCE_EN.
- Defined:
  - force and force_sel ports exist.
  - When force=1, the only grant candidate is force_sel, and it is granted only if free and in_valid[force_sel]=1.
  - ptr does not advance on forced grants.
  - force_sel ≥ N gives no grant.
  - When force=0, behaviour is identical to the undefined case.
- Undefined: the ports are absent and the block is pure round-robin.

## Structure
- Shared package mux_pkg holds the default WIDTH/N constants and a clog2-safe index helper, shared with other selector blocks.
- One sub-module, rr_arbiter, holds the pointer register and the combinational rotate/priority-encode.
  - Inputs: req[N], adv, plus force/force_sel under the macro.
  - Outputs: gnt one-hot, gnt_idx, gnt_any.
- Top level holds the output register and the in_ready gating.

## Test plan
- Reset then idle: rst=1 for 2 cycles → out_valid=0, out_data=0, out_chan=0, in_ready=0000.
- Single channel, N=4, WIDTH=4: in_valid=0100, in_data[ch2]=4'hA, out_ready=1 → in_ready=0100 and, next cycle, out_data=A, out_chan=2.
- All valid, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3, with wrap checked.
- Backpressure: out_ready=0 with the word held → all in_ready=0 and out_data stable for 5 cycles. Raising out_ready then causes drain and reload in the same cycle.
- Reset mid-stream: assert rst while out_valid=1 → next cycle out_valid=0, and the next grant starts from ch0.
- MUX_FORCE_EN: force=1, force_sel=3, in_valid=1111 → only ch3 is granted each cycle and ptr is unchanged. With force_sel=3 and in_valid[3]=0 → no grant.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel-selector family (rr_mux and siblings).
package mux_pkg;

    localparam int MUX_WIDTH = 4;
    localparam int MUX_N     = 4;

    // Index width that never collapses to zero bits, even for a single-entry set.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: N producer channels in, one registered consumer stream out.
// The force_en/force_sel pair only exists when MUX_FORCE_EN is defined.
interface rr_mux_if #(
    parameter int WIDTH = mux_pkg::MUX_WIDTH,
    parameter int N     = mux_pkg::MUX_N
);
    import mux_pkg::*;

    localparam int SELW = idx_w(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_chan;
`ifdef MUX_FORCE_EN
    // force is a reserved word, so the override request is force_en.
    logic               force_en;
    logic [SELW-1:0]    force_sel;
`endif

    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef MUX_FORCE_EN
        input  force_en, force_sel,
`endif
        output in_ready, out_data, out_valid, out_chan
    );

    modport master (
        output in_data, in_valid, out_ready,
`ifdef MUX_FORCE_EN
        output force_en, force_sel,
`endif
        input  in_ready, out_data, out_valid, out_chan
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pointer plus rotate/priority-encode; the grant is the first requester at or after ptr.
// With MUX_FORCE_EN, force_en restricts the grant to force_sel and freezes the pointer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = MUX_N,
    localparam int SELW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            adv,
`ifdef MUX_FORCE_EN
    input  logic            force_en,
    input  logic [SELW-1:0] force_sel,
`endif
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;
    logic [SELW:0]   cand;

    always_comb begin
        rr_idx = '0;
        rr_any = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(N)) begin
                cand = cand - (SELW+1)'(N);
            end
            if (!rr_any && req[cand[SELW-1:0]]) begin
                rr_any = 1'b1;
                rr_idx = cand[SELW-1:0];
            end
        end
    end

`ifdef MUX_FORCE_EN
    logic force_ok;
    assign force_ok = ({1'b0, force_sel} < (SELW+1)'(N)) && req[force_sel];

    always_comb begin
        gnt_idx = rr_idx;
        gnt_any = rr_any;
        if (force_en) begin
            gnt_idx = force_sel;
            gnt_any = force_ok;
        end
    end
`else
    assign gnt_idx = rr_idx;
    assign gnt_any = rr_any;
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign gnt[gi] = gnt_any && (gnt_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
`ifdef MUX_FORCE_EN
        if (adv && gnt_any && !force_en) begin
`else
        if (adv && gnt_any) begin
`endif
            ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-input registered stream selector with round-robin arbitration and one-cycle latency.
// Define MUX_FORCE_EN to add the force_en/force_sel explicit-select override.
module rr_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int N     = MUX_N
) (
    input  logic     clk,
    input  logic     rst,
    rr_mux_if.slave  bus
);

    localparam int SELW = idx_w(N);

    logic [WIDTH-1:0] word [N];
    logic [N-1:0]     gnt;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;
    logic             free;
    logic             take;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            assign word[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Output slot can take a new word if empty or being drained this cycle.
    assign free = !out_valid_q || bus.out_ready;
    assign take = free && gnt_any && !rst;

    rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.in_valid),
        .adv      (take),
`ifdef MUX_FORCE_EN
        .force_en (bus.force_en),
        .force_sel(bus.force_sel),
`endif
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    assign bus.in_ready = (free && !rst) ? gnt : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (take) begin
            out_data_d  = word[gnt_idx];
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: reference grant model feeding a scoreboard queue,
// plus directed cases for reset, wrap, backpressure, mid-stream reset and (MUX_FORCE_EN) force.
module tb_rr_mux;
    import mux_pkg::*;

    localparam int W = 4;
    localparam int N = 4;

    typedef struct {
        int           chan;
        logic [W-1:0] data;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_mux_if #(.WIDTH(W), .N(N)) mif ();

    rr_mux #(.WIDTH(W), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(mif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state, advanced at each falling edge from the stable inputs.
    sb_item_t sbq[$];
    logic     m_valid = 1'b0;
    int       m_ptr   = 0;

    initial begin
        logic         free;
        int           g;
        int           c;
        logic [N-1:0] exp_rdy;
        sb_item_t     e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_in_ready", 32'(mif.in_ready), 32'd0);
                m_valid = 1'b0;
                m_ptr   = 0;
                sbq.delete();
            end else begin
                free = !m_valid || mif.out_ready;
                g = -1;
`ifdef MUX_FORCE_EN
                if (mif.force_en) begin
                    if (int'(mif.force_sel) < N && mif.in_valid[mif.force_sel])
                        g = int'(mif.force_sel);
                end else
`endif
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && mif.in_valid[c]) g = c;
                end
                if (!free) g = -1;
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("in_ready", 32'(mif.in_ready), 32'(exp_rdy));
                chk("out_valid", 32'(mif.out_valid), 32'(m_valid));
                if (m_valid && sbq.size() > 0) begin
                    e = sbq[0];
                    chk("sb_data", 32'(mif.out_data), 32'(e.data));
                    chk("sb_chan", 32'(mif.out_chan), 32'(e.chan));
                    if (mif.out_ready) begin
                        $display("txn chan=%0d data=%0h", e.chan, e.data);
                        void'(sbq.pop_front());
                    end
                end
                if (g >= 0) begin
                    e.chan = g;
                    e.data = mif.in_data[g*W +: W];
                    sbq.push_back(e);
                    m_valid = 1'b1;
`ifdef MUX_FORCE_EN
                    if (!mif.force_en) m_ptr = (g + 1) % N;
`else
                    m_ptr = (g + 1) % N;
`endif
                end else if (free) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        mif.in_valid  = '0;
        mif.in_data   = '0;
        mif.out_ready = 1'b0;
`ifdef MUX_FORCE_EN
        mif.force_en  = 1'b0;
        mif.force_sel = '0;
`endif
        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(mif.out_valid), 32'd0);
        chk("rst_data", 32'(mif.out_data), 32'd0);
        chk("rst_chan", 32'(mif.out_chan), 32'd0);
        chk("rst_ready", 32'(mif.in_ready), 32'd0);
        rst = 1'b0;

        // Single channel 2
        mif.in_valid  = 4'b0100;
        mif.in_data   = 16'h0A00;
        mif.out_ready = 1'b1;
        #1;
        chk("single_ready", 32'(mif.in_ready), 32'h4);
        @(posedge clk); #1;
        mif.in_valid = '0;
        chk("single_data", 32'(mif.out_data), 32'hA);
        chk("single_chan", 32'(mif.out_chan), 32'd2);

        // All valid: fair rotation with wrap, starting from a fresh pointer
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mif.in_valid = 4'hF;
        mif.in_data  = 16'h4321;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("seq_chan", 32'(mif.out_chan), 32'(k % 4));
        end

        // Backpressure: word from ch3 (data 4) must hold
        mif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_ready", 32'(mif.in_ready), 32'd0);
            chk("bp_data", 32'(mif.out_data), 32'h4);
            chk("bp_chan", 32'(mif.out_chan), 32'd3);
        end
        mif.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(mif.in_ready), 32'h1);
        @(posedge clk); #1;
        chk("bp_reload_valid", 32'(mif.out_valid), 32'd1);
        chk("bp_reload_chan", 32'(mif.out_chan), 32'd0);
        chk("bp_reload_data", 32'(mif.out_data), 32'h1);

        // Reset mid-stream: word discarded, pointer back to ch0
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(mif.out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_chan", 32'(mif.out_chan), 32'd0);

`ifdef MUX_FORCE_EN
        // Forced selection of ch3; pointer must not move
        mif.force_en  = 1'b1;
        mif.force_sel = 2'd3;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("force_chan", 32'(mif.out_chan), 32'd3);
        end
        mif.force_en = 1'b0;
        @(posedge clk); #1;
        chk("force_ptr_hold", 32'(mif.out_chan), 32'd1);
        mif.force_en = 1'b1;
        mif.in_valid = 4'b0111;
        #1;
        chk("force_nogrant", 32'(mif.in_ready), 32'd0);
        @(posedge clk); #1;
        mif.force_en = 1'b0;
`endif

        // Random traffic checked by the scoreboard
        for (int k = 0; k < 300; k++) begin
            mif.in_valid  = N'($urandom);
            mif.in_data   = (N*W)'($urandom);
            mif.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_FORCE_EN
            mif.force_en  = ($urandom_range(0, 7) == 0);
            mif.force_sel = 2'($urandom);
`endif
            @(posedge clk); #1;
        end

        mif.in_valid  = '0;
        mif.out_ready = 1'b1;
`ifdef MUX_FORCE_EN
        mif.force_en  = 1'b0;
`endif
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 32'(mif.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
